// File: rtl/icache_pkg.sv
// Shared types and derived geometry for the instruction cache.
// Address layout: tag | index | word offset | byte offset.
package icache_pkg;

    localparam int ADDR_W     = 32;
    localparam int INDEX_BITS = 4;
    localparam int OFFSET_W   = 2;

    localparam int LSB_IDX = 2 + OFFSET_W;
    localparam int LSB_TAG = LSB_IDX + INDEX_BITS;
    localparam int TAG_W   = ADDR_W - LSB_TAG;
    localparam int LINES   = 1 << INDEX_BITS;
    localparam int WORDS   = 1 << OFFSET_W;

    localparam logic [31:0] NOP_INSTR = 32'h0000_0013;

    typedef enum logic [1:0] {
        IDLE   = 2'd0,
        REFILL = 2'd1,
        UPDATE = 2'd2
    } state_t;

endpackage

// File: rtl/icache_refill_ctrl_if.sv
// Word-wide instruction memory read bus.
// The cache is the master; the memory answers with mem_valid.
interface icache_refill_ctrl_if;
    import icache_pkg::*;

    logic              mem_req;
    logic [ADDR_W-1:0] mem_addr;
    logic [31:0]       mem_rdata;
    logic              mem_valid;

    modport master (
        output mem_req,
        output mem_addr,
        input  mem_rdata,
        input  mem_valid
    );

    modport slave (
        input  mem_req,
        input  mem_addr,
        output mem_rdata,
        output mem_valid
    );

endinterface

// File: rtl/icache_data_array.sv
// Data, tag and valid storage for the direct-mapped cache.
// Reads are asynchronous; writes and the valid clear are synchronous.
module icache_data_array
    import icache_pkg::*;
(
    input  logic                  clk,
    input  logic                  rst,
    input  logic                  clr,
    input  logic                  we,
    input  logic [INDEX_BITS-1:0] widx,
    input  logic [OFFSET_W-1:0]   woff,
    input  logic [31:0]           wdata,
    input  logic                  tvwe,
    input  logic [TAG_W-1:0]      wtag,
    input  logic                  vset,
    input  logic [INDEX_BITS-1:0] ridx,
    input  logic [OFFSET_W-1:0]   roff,
    output logic [31:0]           rdata,
    output logic [TAG_W-1:0]      rtag,
    output logic                  rvalid
);

    logic [31:0]      data_q [LINES][WORDS];
    logic [TAG_W-1:0] tag_q  [LINES];
    logic [LINES-1:0] valid_q;

    always_ff @(posedge clk) begin
        if (we)
            data_q[widx][woff] <= wdata;
        if (tvwe)
            tag_q[widx] <= wtag;
    end

    // A clear in the same cycle as a line update leaves the line invalid.
    always_ff @(posedge clk) begin
        if (rst || clr)
            valid_q <= '0;
        else if (tvwe)
            valid_q[widx] <= vset;
    end

    assign rdata  = data_q[ridx][roff];
    assign rtag   = tag_q[ridx];
    assign rvalid = valid_q[ridx];

endmodule

// File: rtl/icache_refill_ctrl.sv
// Direct-mapped I-cache controller: combinational hits, stalling
// whole-line refill from word-wide instruction memory.
module icache_refill_ctrl
    import icache_pkg::*;
(
    input  logic                 clk,
    input  logic                 rst,
    input  logic                 cpu_req,
    input  logic [ADDR_W-1:0]    cpu_addr,
    output logic [31:0]          cpu_instr,
    output logic                 cpu_stall,
    input  logic                 flush,
    icache_refill_ctrl_if.master mem
);

    state_t              state_q, state_d;
    logic [ADDR_W-1:0]   base_q;
    logic [OFFSET_W-1:0] cnt_q;
    logic                abort_q;

    logic [31:0]      rdata;
    logic [TAG_W-1:0] rtag;
    logic             rvalid;
    logic             idle, hit, miss, beat, last;
    logic             addr_unused;

    assign addr_unused = ^cpu_addr[1:0];

    assign idle = (state_q == IDLE);
    assign hit  = cpu_req && idle && !flush && rvalid
               && (rtag == cpu_addr[ADDR_W-1:LSB_TAG]);
    assign miss = cpu_req && idle && !hit && !flush;
    assign beat = (state_q == REFILL) && mem.mem_valid;
    assign last = (cnt_q == OFFSET_W'(WORDS - 1));

    always_comb begin
        state_d      = state_q;
        cpu_stall    = 1'b0;
        mem.mem_req  = 1'b0;
        mem.mem_addr = '0;
        cpu_instr    = hit ? rdata : NOP_INSTR;
        unique case (state_q)
            IDLE: begin
                cpu_stall = cpu_req && !hit;
                if (miss)
                    state_d = REFILL;
            end
            REFILL: begin
                cpu_stall    = 1'b1;
                mem.mem_req  = 1'b1;
                mem.mem_addr = base_q + ADDR_W'({cnt_q, 2'b00});
                if (beat && last)
                    state_d = UPDATE;
            end
            UPDATE: begin
                cpu_stall = 1'b1;
                state_d   = IDLE;
            end
            default: state_d = IDLE;
        endcase
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q <= IDLE;
            base_q  <= '0;
            cnt_q   <= '0;
            abort_q <= 1'b0;
        end else begin
            state_q <= state_d;
            if (miss) begin
                base_q <= {cpu_addr[ADDR_W-1:LSB_IDX], {LSB_IDX{1'b0}}};
                cnt_q  <= '0;
            end else if (beat) begin
                cnt_q <= cnt_q + 1'b1;
            end
            // A flush during refill must keep the fetched line invalid.
            if (state_q == UPDATE)
                abort_q <= 1'b0;
            else if (flush && !idle)
                abort_q <= 1'b1;
        end
    end

    icache_data_array u_array (
        .clk    (clk),
        .rst    (rst),
        .clr    (flush),
        .we     (beat && !rst),
        .widx   (base_q[LSB_TAG-1:LSB_IDX]),
        .woff   (cnt_q),
        .wdata  (mem.mem_rdata),
        .tvwe   ((state_q == UPDATE) && !rst),
        .wtag   (base_q[ADDR_W-1:LSB_TAG]),
        .vset   (!abort_q),
        .ridx   (cpu_addr[LSB_TAG-1:LSB_IDX]),
        .roff   (cpu_addr[LSB_IDX-1:2]),
        .rdata  (rdata),
        .rtag   (rtag),
        .rvalid (rvalid)
    );

endmodule

// File: tb/tb_icache_refill_ctrl.sv
// Bench for icache_refill_ctrl: vector table, directed refill
// sequences and random traffic against a line-level cache model.
module tb_icache_refill_ctrl;
    import icache_pkg::*;

    logic        clk = 1'b0;
    logic        rst, cpu_req, flush, mvin;
    logic [31:0] cpu_addr, cpu_instr;
    logic        cpu_stall;

    icache_refill_ctrl_if bus();

    icache_refill_ctrl dut (
        .clk       (clk),
        .rst       (rst),
        .cpu_req   (cpu_req),
        .cpu_addr  (cpu_addr),
        .cpu_instr (cpu_instr),
        .cpu_stall (cpu_stall),
        .flush     (flush),
        .mem       (bus)
    );

    initial forever #5 clk = ~clk;

    function automatic logic [31:0] mem_word(input logic [31:0] a);
        logic [31:0] w;
        w = a >> 2;
        if (a < 32'h20)
            return ((32'd10 << w) << 20) | ((w + 1) << 7) | 32'h13;
        return (a * 32'h9E37_79B1) ^ 32'h13;
    endfunction

    assign bus.mem_rdata = mem_word(bus.mem_addr);
    assign bus.mem_valid = mvin;

    int checks = 0;
    int errors = 0;
    int ncyc   = 0;

    logic [31:0] m_data [LINES][WORDS];
    logic [31:0] m_tag  [LINES];
    bit          m_valid[LINES];
    logic [31:0] m_q[$];
    bit          m_upd, m_abort;
    logic [31:0] m_base;

    logic [31:0] o_instr, o_maddr;
    bit          o_stall, o_mreq;
    logic [31:0] seen[$];

    function automatic bit m_idle();
        return m_q.size() == 0 && !m_upd;
    endfunction

    function automatic bit m_hit(input bit req, input logic [31:0] a, input bit fl);
        int idx;
        idx = (a / 16) % LINES;
        return req && m_idle() && !fl && m_valid[idx] && m_tag[idx] == a / 256;
    endfunction

    function automatic void m_clear();
        foreach (m_valid[i]) m_valid[i] = 0;
    endfunction

    function automatic void m_step(input bit req, input logic [31:0] a,
                                   input bit fl, input bit mv, input bit r);
        logic [31:0] w;
        if (r) begin
            m_q.delete();
            m_upd = 0;
            m_abort = 0;
            m_clear();
        end else if (m_idle()) begin
            if (fl)
                m_clear();
            else if (req && !m_hit(req, a, fl)) begin
                m_base = a - a % 16;
                for (int j = 0; j < WORDS; j++)
                    m_q.push_back(m_base + 4 * j);
            end
        end else if (m_q.size() != 0) begin
            if (fl) begin
                m_clear();
                m_abort = 1;
            end
            if (mv) begin
                w = m_q.pop_front();
                m_data[(w / 16) % LINES][(w / 4) % WORDS] = mem_word(w);
                if (m_q.size() == 0)
                    m_upd = 1;
            end
        end else begin
            if (fl)
                m_clear();
            else if (!m_abort) begin
                m_valid[(m_base / 16) % LINES] = 1;
                m_tag[(m_base / 16) % LINES]   = m_base / 256;
            end
            m_upd = 0;
            m_abort = 0;
        end
    endfunction

    task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %h expected %h", nm, act, exp);
        end
    endtask

    task automatic cyc(input bit req, input logic [31:0] a, input bit fl,
                       input bit mv, input bit r);
        logic [31:0] ei, ema;
        bit          es, emr;
        cpu_req  = req;
        cpu_addr = a;
        flush    = fl;
        mvin     = mv;
        rst      = r;
        ei  = m_hit(req, a, fl) ? m_data[(a / 16) % LINES][(a / 4) % WORDS] : NOP_INSTR;
        es  = !m_idle() || (req && !m_hit(req, a, fl));
        emr = m_q.size() != 0;
        ema = emr ? m_q[0] : 32'h0;
        @(negedge clk);
        o_instr = cpu_instr;
        o_stall = cpu_stall;
        o_mreq  = bus.mem_req;
        o_maddr = bus.mem_addr;
        if (!r) begin
            checks++;
            if (o_instr !== ei || o_stall !== es || o_mreq !== emr || o_maddr !== ema) begin
                errors++;
                $display("FAIL model cyc %0d: instr %h/%h stall %b/%b mreq %b/%b maddr %h/%h",
                         ncyc, o_instr, ei, o_stall, es, o_mreq, emr, o_maddr, ema);
            end
        end
        m_step(req, a, fl, mv, r);
        ncyc++;
        @(posedge clk);
        #1;
    endtask

    // Fetch a until it hits; pat gives mem_valid per REFILL cycle.
    task automatic run_miss(input logic [31:0] a, input bit [15:0] pat,
                            input int plen, input int fl_at, output int nst);
        int  k, rc;
        bit  mv, fl, inref, done;
        k = 0;
        rc = 0;
        nst = 0;
        done = 0;
        seen.delete();
        for (int i = 0; i < 60 && !done; i++) begin
            inref = m_q.size() != 0;
            mv = 0;
            fl = 0;
            if (inref) begin
                rc++;
                fl = (rc == fl_at);
                mv = (k < plen) ? pat[k] : 1'b1;
                k++;
            end
            cyc(1'b1, a, fl, mv, 1'b0);
            if (o_mreq && mv)
                seen.push_back(o_maddr);
            if (o_stall)
                nst++;
            else
                done = 1;
        end
        if (!done)
            chk("refill_timeout", 32'd1, 32'd0);
    endtask

    task automatic chk_seen(input string nm, input logic [31:0] base, input int n);
        chk({nm, "_beats"}, seen.size(), n);
        for (int i = 0; i < n && i < seen.size(); i++)
            chk(nm, seen[i], base + 4 * (i % WORDS));
    endtask

    typedef struct {
        bit          req;
        logic [31:0] addr;
        bit          fl;
        logic [31:0] instr;
        bit          stall;
        bit          mreq;
    } vec_t;

    vec_t vt[7];
    int   nst;

    initial begin
        vt[0] = '{1, 32'h4, 0, 32'h0140_0113, 0, 0};
        vt[1] = '{1, 32'h8, 0, 32'h0280_0193, 0, 0};
        vt[2] = '{1, 32'hC, 0, 32'h0500_0213, 0, 0};
        vt[3] = '{1, 32'h0, 0, 32'h00A0_0093, 0, 0};
        vt[4] = '{0, 32'h0, 0, NOP_INSTR,     0, 0};
        vt[5] = '{1, 32'h4, 1, NOP_INSTR,     1, 0};
        vt[6] = '{0, 32'h4, 0, NOP_INSTR,     0, 0};

        rst = 1; cpu_req = 0; cpu_addr = 0; flush = 0; mvin = 0;
        @(posedge clk);
        #1;
        cyc(0, 0, 0, 0, 1);
        cyc(0, 0, 0, 0, 1);
        cyc(0, 0, 0, 1, 0);
        chk("rst_stall", o_stall, 0);
        chk("rst_instr", o_instr, NOP_INSTR);
        chk("rst_mreq", o_mreq, 0);
        chk("rst_maddr", o_maddr, 0);

        run_miss(32'h0, 16'h0, 0, 0, nst);
        chk("cold_stalls", nst, 6);
        chk_seen("cold_addr", 32'h0, 4);
        chk("cold_instr", o_instr, 32'h00A0_0093);

        foreach (vt[i]) begin
            cyc(vt[i].req, vt[i].addr, vt[i].fl, 1'b1, 1'b0);
            chk($sformatf("vec%0d_instr", i), o_instr, vt[i].instr);
            chk($sformatf("vec%0d_stall", i), o_stall, vt[i].stall);
            chk($sformatf("vec%0d_mreq", i), o_mreq, vt[i].mreq);
        end

        run_miss(32'h100, 16'h0, 0, 0, nst);
        chk("evict1_stalls", nst, 6);
        chk_seen("evict1_addr", 32'h100, 4);
        chk("evict1_instr", o_instr, mem_word(32'h100));
        run_miss(32'h0, 16'h0, 0, 0, nst);
        chk("evict0_stalls", nst, 6);
        chk_seen("evict0_addr", 32'h0, 4);
        chk("evict0_instr", o_instr, 32'h00A0_0093);

        run_miss(32'h10, 16'h00B2, 8, 0, nst);
        chk("bp_stalls", nst, 10);
        chk_seen("bp_addr", 32'h10, 4);
        chk("bp_instr", o_instr, 32'h0A00_0293);

        run_miss(32'h20, 16'h0, 0, 2, nst);
        chk("flush_stalls", nst, 12);
        chk_seen("flush_addr", 32'h20, 8);
        run_miss(32'h0, 16'h0, 0, 0, nst);
        chk("flush_line0_stalls", nst, 6);

        cyc(1, 32'h30, 0, 0, 0);
        cyc(1, 32'h30, 0, 1, 0);
        cyc(1, 32'h30, 0, 1, 0);
        cyc(0, 32'h30, 0, 1, 1);
        for (int i = 0; i < 2; i++) begin
            cyc(0, 32'h0, 0, 1, 0);
            chk("rstmid_stall", o_stall, 0);
            chk("rstmid_mreq", o_mreq, 0);
            chk("rstmid_maddr", o_maddr, 0);
        end
        run_miss(32'h0, 16'h0, 0, 0, nst);
        chk("rstmid_refetch", nst, 6);

        for (int i = 0; i < 3000; i++) begin
            logic [31:0] a;
            a = ($urandom_range(0, 2) << 8) | ($urandom_range(0, 3) << 4)
              | ($urandom_range(0, 3) << 2);
            cyc($urandom_range(0, 9) < 8, a, $urandom_range(0, 49) == 0,
                $urandom_range(0, 9) < 7, $urandom_range(0, 149) == 0);
        end

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
